// File: rtl/ring_fifo_pkg.sv
// Shared FIFO sizing helpers: pointer and occupancy widths for ring_fifo and sibling FIFOs.
// Pure compile-time functions and constants; no logic.
package fifo_pkg;

    // Pointer width; at least one bit so a DEPTH of 1 or 2 still gets a real register
    function automatic int ptr_bits(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

    // Occupancy must represent 0..depth inclusive
    function automatic int ne_bits(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int DEF_DEPTH   = 3;
    localparam int DEF_NE_BITS = ne_bits(DEF_DEPTH);

    typedef logic [DEF_NE_BITS-1:0] def_count_t;

endpackage

// File: rtl/ring_fifo_ptr.sv
// ring_ptr: wrapping pointer 0..DEPTH-1 for non-power-of-two circular buffers.
// Latency: ptr updates one cycle after inc/clear; reset wins over clear, clear over inc.
// Backpressure: none; the caller gates inc with its own accept condition.
module ring_ptr
    import fifo_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       clear,
    input  logic                       inc,
    output logic [ptr_bits(DEPTH)-1:0] ptr
);

    localparam int PW = ptr_bits(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (clear) begin
            ptr <= '0;
        end else if (inc) begin
            // Explicit wrap so DEPTH need not be a power of two
            ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/ring_fifo.sv
// ring_fifo: circular-buffer FIFO with thresholds, flush, sticky error flags; RING_FIFO_BYPASS_EN adds empty bypass.
// Latency: push visible on last_entry next cycle (same cycle through bypass when enabled and empty).
// Backpressure: producer watches full; a push while full without a pop is dropped and sets overflow.
module ring_fifo
    import fifo_pkg::*;
#(
    parameter int DEPTH       = 3,
    parameter int BITS        = 8,
    parameter int AFULL_LEVEL = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      add,
    input  logic                      remove,
    input  logic                      flush,
    input  logic [BITS-1:0]           new_entry,
    output logic [BITS-1:0]           last_entry,
    output logic                      empty,
    output logic                      full,
    output logic                      almost_full,
    output logic [ne_bits(DEPTH)-1:0] num_entries,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int PW = ptr_bits(DEPTH);
    localparam int NE = ne_bits(DEPTH);

    logic [BITS-1:0] mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic            push;
    logic            pop;
    logic            bypass;
    logic            ovf_set;
    logic            unf_set;

    assign empty       = (num_entries == '0);
    assign full        = (num_entries == NE'(DEPTH));
    assign almost_full = (num_entries >= NE'(AFULL_LEVEL));

    // Flush swallows any add/remove presented in the same cycle
    always_comb begin
        bypass = 1'b0;
`ifdef RING_FIFO_BYPASS_EN
        bypass = empty && add && remove && !flush;
`endif
        push    = !flush && add && (!full || remove) && !bypass;
        pop     = !flush && remove && !empty;
        ovf_set = !flush && add && full && !remove;
        unf_set = !flush && remove && empty && !bypass;
    end

    ring_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (flush),
        .inc     (pop),
        .ptr     (rd_ptr)
    );

    ring_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (flush),
        .inc     (push),
        .ptr     (wr_ptr)
    );

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= new_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            num_entries <= '0;
        end else if (flush) begin
            num_entries <= '0;
        end else begin
            num_entries <= num_entries + NE'(push) - NE'(pop);
        end
    end

    // Sticky flags survive flush; only reset clears them
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_set) overflow  <= 1'b1;
            if (unf_set) underflow <= 1'b1;
        end
    end

`ifdef RING_FIFO_BYPASS_EN
    assign last_entry = empty ? new_entry : mem[rd_ptr];
`else
    assign last_entry = mem[rd_ptr];
`endif

endmodule

// File: tb/tb_ring_fifo.sv
// Scoreboard bench for ring_fifo (DEPTH=3, BITS=8, AFULL_LEVEL=2): queue-based reference model,
// directed scenarios followed by randomized traffic; monitor checks status and popped data.
module tb_ring_fifo;

    localparam int DEPTH = 3;
    localparam int BITS  = 8;
    localparam int AFL   = 2;
    localparam int NE    = $clog2(DEPTH + 1);
`ifdef RING_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset_n;
    logic            add;
    logic            remove;
    logic            flush;
    logic [BITS-1:0] new_entry;
    logic [BITS-1:0] last_entry;
    logic            empty;
    logic            full;
    logic            almost_full;
    logic [NE-1:0]   num_entries;
    logic            overflow;
    logic            underflow;

    always #5 clk = ~clk;

    ring_fifo #(.DEPTH(DEPTH), .BITS(BITS), .AFULL_LEVEL(AFL)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .add         (add),
        .remove      (remove),
        .flush       (flush),
        .new_entry   (new_entry),
        .last_entry  (last_entry),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .num_entries (num_entries),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    typedef struct {
        logic [NE-1:0]   num;
        logic            emp;
        logic            ful;
        logic            af;
        logic            ovf;
        logic            unf;
        logic            pop_vld;
        logic [BITS-1:0] dat;
    } exp_t;

    exp_t            sb[$];
    logic [BITS-1:0] mq[$];
    bit              m_ovf;
    bit              m_unf;
    int              checks;
    int              failures;

    // One cycle of stimulus: record the expected view of this cycle, advance the model, drive pins
    task automatic cyc(input bit r, input bit a, input bit rm, input bit f, input logic [BITS-1:0] d);
        exp_t e;
        int   n;
        @(posedge clk);
        #1;
        n         = mq.size();
        e.num     = NE'(n);
        e.emp     = (n == 0);
        e.ful     = (n == DEPTH);
        e.af      = (n >= AFL);
        e.ovf     = m_ovf;
        e.unf     = m_unf;
        e.pop_vld = 1'b0;
        e.dat     = '0;
        if (!r) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (f) begin
            mq.delete();
        end else if (BYP && n == 0 && a && rm) begin
            e.pop_vld = 1'b1;
            e.dat     = d;
        end else begin
            if (rm && n == 0) m_unf = 1'b1;
            if (a && n == DEPTH && !rm) m_ovf = 1'b1;
            if (rm && n > 0) begin
                e.pop_vld = 1'b1;
                e.dat     = mq.pop_front();
            end
            if (a && (n < DEPTH || rm)) mq.push_back(d);
        end
        sb.push_back(e);
        reset_n   = r;
        add       = a;
        remove    = rm;
        flush     = f;
        new_entry = d;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if ({num_entries, empty, full, almost_full, overflow, underflow} !==
                    {e.num, e.emp, e.ful, e.af, e.ovf, e.unf}) begin
                    failures++;
                    $display("FAIL status t=%0t: got num=%0d e=%b f=%b af=%b ovf=%b unf=%b, want num=%0d e=%b f=%b af=%b ovf=%b unf=%b",
                             $time, num_entries, empty, full, almost_full, overflow, underflow,
                             e.num, e.emp, e.ful, e.af, e.ovf, e.unf);
                end
                if (e.pop_vld) begin
                    checks++;
                    if (last_entry !== e.dat) begin
                        failures++;
                        $display("FAIL pop_data t=%0t: got %h want %h", $time, last_entry, e.dat);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int pa;
        int pr;
        checks    = 0;
        failures  = 0;
        m_ovf     = 1'b0;
        m_unf     = 1'b0;
        reset_n   = 1'b0;
        add       = 1'b0;
        remove    = 1'b0;
        flush     = 1'b0;
        new_entry = '0;
        repeat (2) @(posedge clk);

        // Fill to full then drain in order
        cyc(1, 1, 0, 0, 8'h11);
        cyc(1, 1, 0, 0, 8'h22);
        cyc(1, 1, 0, 0, 8'h33);
        cyc(1, 0, 0, 0, 8'h00);
        repeat (3) cyc(1, 0, 1, 0, 8'h00);
        cyc(1, 0, 0, 0, 8'h00);

        // Pointer wrap at occupancy 1-2
        cyc(1, 1, 0, 0, 8'h01);
        cyc(1, 1, 0, 0, 8'h02);
        for (int i = 3; i <= 7; i++) cyc(1, 1, 1, 0, 8'(i));
        cyc(1, 0, 1, 0, 8'h00);
        cyc(1, 0, 1, 0, 8'h00);
        cyc(1, 0, 0, 0, 8'h00);

        // Overflow, then simultaneous push/pop while full
        cyc(1, 1, 0, 0, 8'hA0);
        cyc(1, 1, 0, 0, 8'hA1);
        cyc(1, 1, 0, 0, 8'hA2);
        cyc(1, 1, 0, 0, 8'h44);
        cyc(1, 1, 1, 0, 8'h44);
        cyc(1, 0, 0, 0, 8'h00);
        repeat (3) cyc(1, 0, 1, 0, 8'h00);

        // Underflow and empty add+remove
        cyc(1, 0, 1, 0, 8'h00);
        cyc(1, 1, 1, 0, 8'h5A);
        cyc(1, 0, 0, 0, 8'h00);
        cyc(1, 0, 1, 0, 8'h00);

        // almost_full threshold and flush keeping flags
        cyc(1, 1, 0, 0, 8'h61);
        cyc(1, 1, 0, 0, 8'h62);
        cyc(1, 0, 0, 0, 8'h00);
        cyc(1, 1, 1, 1, 8'h63);
        cyc(1, 0, 0, 0, 8'h00);

        // Reset mid-stream
        cyc(1, 1, 0, 0, 8'h71);
        cyc(1, 1, 0, 0, 8'h72);
        cyc(0, 1, 1, 0, 8'h73);
        cyc(1, 0, 0, 0, 8'h00);

        // Randomized traffic with shifting add/remove bias
        for (int ph = 0; ph < 3; ph++) begin
            pa = 70 - 20 * ph;
            pr = 30 + 20 * ph;
            for (int k = 0; k < 800; k++) begin
                cyc($urandom_range(0, 99) != 0,
                    $urandom_range(0, 99) < pa,
                    $urandom_range(0, 99) < pr,
                    $urandom_range(0, 19) == 0,
                    8'($urandom));
            end
        end
        cyc(1, 0, 0, 0, 8'h00);

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: scoreboard entries left %0d want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
